// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order requests to instruction memory,
// a small response FIFO, branch redirect with stale-response discard, and the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HLT,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_inst [FIFO_DEPTH];

  logic          redirect;
  logic [CW:0]   credit_used;
  logic          credit_ok;
  logic          req_accept;
  logic          rsp_drop;
  logic          push;
  logic          pop;

  // Request side: a request is only offered when its response is guaranteed a FIFO slot.
  assign redirect       = branch_taken & ~HLT;
  assign credit_used    = {1'b0, outstanding} + {1'b0, count};
  assign credit_ok      = credit_used < DEPTH_C;
  assign imem_req_valid = ~RST & ~redirect & credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_accept     = imem_req_valid & imem_req_ready;

  // Response side: stale words are consumed first, a redirect drops the current word too.
  assign rsp_drop = imem_rsp_valid & (discard != '0);
  assign push     = imem_rsp_valid & (discard == '0) & ~redirect;
  assign pop      = ~HLT & ~redirect & (count != '0);

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= rsp_pc;
      fifo_inst[wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      IF_ID_pc    <= RESET_PC;
      IF_ID_inst  <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_accept) - CW'(imem_rsp_valid);
      if (redirect) begin
        // After a redirect every word still in flight belongs to the old path.
        fetch_pc   <= word_align(branch_target);
        rsp_pc     <= word_align(branch_target);
        count      <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        discard    <= outstanding - CW'(imem_rsp_valid);
        IF_ID_inst <= '0;
      end else begin
        if (req_accept)
          fetch_pc <= pc_inc(fetch_pc);
        if (push) begin
          rsp_pc <= pc_inc(rsp_pc);
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (rsp_drop)
          discard <= discard - CW'(1);
        // IF/ID stage boundary
        if (!HLT) begin
          if (pop) begin
            IF_ID_pc   <= fifo_pc[rd_ptr];
            IF_ID_inst <= fifo_inst[rd_ptr];
          end else begin
            IF_ID_inst <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios and random traffic against a queue-based model
// with an in-order variable-latency instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
  localparam int          DEPTH = 4;

  logic        CLK;
  logic        RST;
  logic        HLT;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .HLT           (HLT),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_inst    (IF_ID_inst)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  req_t        mq[$];
  ent_t        fq[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_inst;
  int          epoch;
  int          cyc;
  int          last_due;
  int          lat;
  int          n_acc;
  bit          known;
  int          n_chk;
  int          n_err;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2] ^ 30'h15A3_C96E, 2'b01};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    mq.delete();
    fq.delete();
    m_fetch_pc = RPC;
    m_if_pc    = RPC;
    m_if_inst  = 32'h0;
    last_due   = cyc;
    known      = 1'b1;
  endtask

  // One clock cycle: memory answers, outputs compared at the falling edge, model advances.
  task automatic step();
    logic rsp_now, redir, exp_valid, acc;
    req_t r;
    ent_t e;
    int   due;
    rsp_now        = !RST && (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(mq[0].addr) : $urandom();
    @(negedge CLK);
    redir     = branch_taken && !HLT;
    exp_valid = !RST && !redir && ((mq.size() + fq.size()) < DEPTH);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_valid});
    if (known) begin
      chk("req_addr", imem_req_addr, m_fetch_pc);
      chk("if_id_pc", IF_ID_pc, m_if_pc);
      chk("if_id_inst", IF_ID_inst, m_if_inst);
    end
    acc = exp_valid && imem_req_ready;
    if (RST) begin
      model_reset();
    end else begin
      if (!HLT) begin
        if (redir || fq.size() == 0) begin
          m_if_inst = 32'h0;
        end else begin
          e = fq.pop_front();
          m_if_pc   = e.pc;
          m_if_inst = e.inst;
        end
      end
      if (rsp_now) begin
        r = mq.pop_front();
        if (r.epoch == epoch && !redir) begin
          e.pc   = r.addr;
          e.inst = mem_word(r.addr);
          fq.push_back(e);
        end
      end
      if (acc) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.addr  = m_fetch_pc;
        r.epoch = epoch;
        r.due   = due;
        mq.push_back(r);
        m_fetch_pc = m_fetch_pc + 32'd4;
        n_acc++;
      end
      if (redir) begin
        epoch++;
        fq.delete();
        m_fetch_pc = {branch_target[31:2], 2'b00};
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Straight-line fetch from RESET_PC, entered in the first cycle after RST falls.
  task automatic straight(input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      if (i < 3) begin
        chk("sl_bubble", IF_ID_inst, 32'h0);
      end else begin
        pc = RPC + 32'(4 * (i - 3));
        chk("sl_pc", IF_ID_pc, pc);
        chk("sl_inst", IF_ID_inst, mem_word(pc));
      end
      chk("sl_req_addr", imem_req_addr, RPC + 32'(4 * i));
      step();
    end
  endtask

  initial begin
    logic [31:0] a0;
    logic [31:0] snap_pc;
    logic [31:0] snap_inst;
    int          acc_base;
    int          k;
    bit          found;

    n_chk = 0; n_err = 0; cyc = 0; epoch = 0; last_due = 0; n_acc = 0;
    known = 1'b0; lat = 1;
    RST = 1'b1; HLT = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    // Reset values
    step();
    step();
    chk("rst_if_pc", IF_ID_pc, RPC);
    chk("rst_if_inst", IF_ID_inst, 32'h0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    RST = 1'b0;

    // Straight-line fetch across the 32-bit wrap
    straight(20);

    // Request backpressure
    imem_req_ready = 1'b0;
    a0 = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      chk("bp_addr_stable", imem_req_addr, a0);
      step();
    end
    imem_req_ready = 1'b1;
    repeat (8) step();

    // Credit limit under a decode stall, with an ignored branch
    lat = 3;
    HLT = 1'b1;
    snap_pc   = IF_ID_pc;
    snap_inst = IF_ID_inst;
    acc_base  = n_acc;
    for (int i = 0; i < 12; i++) begin
      branch_taken  = (i == 6);
      branch_target = 32'h0000_0500;
      step();
    end
    branch_taken = 1'b0;
    chk("credit_accepts_le4", {31'b0, (n_acc - acc_base) <= 4}, 32'h1);
    chk("credit_valid_low", {31'b0, imem_req_valid}, 32'h0);
    chk("hlt_pc_held", IF_ID_pc, snap_pc);
    chk("hlt_inst_held", IF_ID_inst, snap_inst);
    HLT = 1'b0;
    repeat (6) step();

    // Redirect with two words in flight
    imem_req_ready = 1'b0;
    repeat (6) step();
    imem_req_ready = 1'b1;
    step();
    step();
    imem_req_ready = 1'b0;
    branch_taken   = 1'b1;
    branch_target  = 32'h0000_0203;
    step();
    branch_taken = 1'b0;
    chk("redir_req_addr", imem_req_addr, 32'h0000_0200);
    chk("redir_discard", 32'(dut.discard), 32'd2);
    chk("redir_bubble", IF_ID_inst, 32'h0);
    imem_req_ready = 1'b1;
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      step();
      k++;
      if (IF_ID_inst !== 32'h0) found = 1'b1;
    end
    chk("redir_target_seen", {31'b0, found}, 32'h1);
    chk("redir_first_pc", IF_ID_pc, 32'h0000_0200);
    chk("redir_first_inst", IF_ID_inst, mem_word(32'h0000_0200));

    // Redirect coinciding with a response and a non-empty FIFO
    lat = 2;
    repeat (8) step();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0340;
    step();
    branch_taken = 1'b0;
    chk("sim_discard", 32'(dut.discard), 32'(mq.size()));
    chk("sim_count", 32'(dut.count), 32'h0);
    chk("sim_bubble", IF_ID_inst, 32'h0);
    chk("sim_req_addr", imem_req_addr, 32'h0000_0340);

    // One-cycle reset in the middle of a burst
    lat = 1;
    repeat (5) step();
    RST = 1'b1;
    step();
    chk("mid_rst_if_pc", IF_ID_pc, RPC);
    chk("mid_rst_if_inst", IF_ID_inst, 32'h0);
    chk("mid_rst_req_addr", imem_req_addr, RPC);
    chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    RST = 1'b0;
    straight(12);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      RST            = ($urandom_range(0, 199) == 0);
      HLT            = ($urandom_range(0, 9) < 3);
      branch_taken   = ($urandom_range(0, 15) == 0);
      branch_target  = $urandom();
      imem_req_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    RST = 1'b0; HLT = 1'b0; branch_taken = 1'b0; imem_req_ready = 1'b1;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
